// File: rtl/line_field_pkg.sv
// Shared constants, pixel encoding and index-width helper for the scrolling line field.
package line_field_pkg;

  localparam int LINE_W     = 640;
  localparam int SCREEN_H   = 480;
  localparam int ROW_HEIGHT = 16;
  localparam int ROWS       = SCREEN_H / ROW_HEIGHT;
  localparam int ROW_SHIFT  = $clog2(ROW_HEIGHT);

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int ROW_W  = idx_width(ROWS);
  localparam int COL_W  = idx_width(LINE_W);
  localparam int FILL_W = $clog2(ROWS + 1);

  typedef enum logic {
    PIX_BLOCKED = 1'b0,
    PIX_OPEN    = 1'b1
  } pix_e;

endpackage

// File: rtl/line_slot_mem.sv
// Circular slot array: one line-wide write port, two single-bit read ports.
module line_slot_mem
  import line_field_pkg::*;
(
  input  logic              clk_i,
  input  logic              we,
  input  logic [ROW_W-1:0]  waddr,
  input  logic [LINE_W-1:0] wdata,
  input  logic [ROW_W-1:0]  pix_slot,
  input  logic [COL_W-1:0]  pix_col,
  output logic              pix_bit,
  input  logic [ROW_W-1:0]  hit_slot,
  input  logic [COL_W-1:0]  hit_col,
  output logic              hit_bit
);

  logic [LINE_W-1:0] slots [ROWS];

  // NOTE: slot storage has no reset; the fill count masks unwritten slots.
  always_ff @(posedge clk_i) begin
    if (we) slots[waddr] <= wdata;
  end

  assign pix_bit = slots[pix_slot][pix_col];
  assign hit_bit = slots[hit_slot][hit_col];

endmodule

// File: rtl/line_field.sv
// Frame-synchronous scrolling store of obstacle lines with pixel reads and collision check.
module line_field
  import line_field_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              line_valid_i,
  input  logic [LINE_W-1:0] line_i,
  output logic              line_ready_o,
  input  logic              frame_start_i,
  input  logic              pix_req_i,
  input  logic [9:0]        hcount_i,
  input  logic [9:0]        vcount_i,
  output logic              pix_o,
  output logic              pix_valid_o,
  input  logic [9:0]        player_col_i,
  output logic              hit_o,
  output logic [FILL_W-1:0] fill_o
);

  localparam int SCAN_W = 10 - ROW_SHIFT;
  localparam logic [ROW_W-1:0]  LAST_SLOT = ROW_W'(ROWS - 1);
  localparam logic [FILL_W-1:0] FULL      = FILL_W'(ROWS);
  localparam logic [FILL_W-1:0] NEAR_FULL = FILL_W'(ROWS - 1);
  localparam logic [SCAN_W-1:0] SCAN_ROWS = SCAN_W'(ROWS);
  localparam logic [9:0]        LINE_END  = 10'(LINE_W);

  logic [LINE_W-1:0] pending;
  logic              pending_full;
  logic [ROW_W-1:0]  head;
  logic [ROW_W-1:0]  new_head;
  logic [FILL_W-1:0] fill;

  logic              accept;
  logic              commit;
  logic [SCAN_W-1:0] scan_row;
  logic [ROW_W-1:0]  pix_slot;
  logic [ROW_W-1:0]  hit_slot;
  logic              pix_bit;
  logic              hit_bit;
  logic              pix_next;
  logic              hit_next;

  function automatic logic [ROW_W-1:0] slot_of(input logic [ROW_W-1:0] base,
                                               input logic [ROW_W-1:0] row);
    logic [ROW_W:0] sum;
    sum = {1'b0, base} + {1'b0, row};
    if (sum >= (ROW_W + 1)'(ROWS)) sum = sum - (ROW_W + 1)'(ROWS);
    return sum[ROW_W-1:0];
  endfunction

  assign line_ready_o = !pending_full;
  assign fill_o       = fill;
  assign accept       = line_valid_i && !pending_full;
  assign commit       = frame_start_i && pending_full;
  assign new_head     = (head == '0) ? LAST_SLOT : head - 1'b1;

  assign scan_row = vcount_i[9:ROW_SHIFT];
  assign pix_slot = slot_of(head, scan_row[ROW_W-1:0]);
  // Post-commit bottom row is the pre-commit row ROWS-2, which the commit does not overwrite.
  assign hit_slot = slot_of(head, ROW_W'(ROWS - 2));

  line_slot_mem u_mem (
    .clk_i    (clk_i),
    .we       (commit),
    .waddr    (new_head),
    .wdata    (pending),
    .pix_slot (pix_slot),
    .pix_col  (hcount_i),
    .pix_bit  (pix_bit),
    .hit_slot (hit_slot),
    .hit_col  (player_col_i),
    .hit_bit  (hit_bit)
  );

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    pix_next = PIX_BLOCKED;
    if (hcount_i < LINE_END && scan_row < SCAN_ROWS) begin
      if (scan_row < SCAN_W'(fill)) pix_next = pix_bit;
      else                          pix_next = PIX_OPEN;
    end
  end

  always_comb begin
    hit_next = 1'b0;
    if (commit && fill >= NEAR_FULL && player_col_i < LINE_END)
      hit_next = (hit_bit == PIX_BLOCKED);
  end

  always_ff @(posedge clk_i) begin
    if (accept) pending <= line_i;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pending_full <= 1'b0;
      head         <= '0;
      fill         <= '0;
      pix_o        <= 1'b0;
      pix_valid_o  <= 1'b0;
      hit_o        <= 1'b0;
    end else begin
      if (accept)      pending_full <= 1'b1;
      else if (commit) pending_full <= 1'b0;
      if (commit) begin
        head <= new_head;
        fill <= (fill == FULL) ? fill : fill + 1'b1;
      end
      pix_valid_o <= pix_req_i;
      if (pix_req_i) pix_o <= pix_next;
      hit_o <= hit_next;
    end
  end

endmodule

// File: tb/tb_line_field.sv
// Scoreboard bench for line_field: reference model of rows, pending line and collision.
module tb_line_field;
  import line_field_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              line_valid;
  logic [LINE_W-1:0] line;
  logic              line_ready;
  logic              frame_start;
  logic              pix_req;
  logic [9:0]        hcount;
  logic [9:0]        vcount;
  logic              pix;
  logic              pix_valid;
  logic [9:0]        player_col;
  logic              hit;
  logic [FILL_W-1:0] fill;

  always #5 clk = ~clk;

  line_field dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .line_valid_i  (line_valid),
    .line_i        (line),
    .line_ready_o  (line_ready),
    .frame_start_i (frame_start),
    .pix_req_i     (pix_req),
    .hcount_i      (hcount),
    .vcount_i      (vcount),
    .pix_o         (pix),
    .pix_valid_o   (pix_valid),
    .player_col_i  (player_col),
    .hit_o         (hit),
    .fill_o        (fill)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic              exp_q[$];
  logic [LINE_W-1:0] model_rows[$];
  logic [LINE_W-1:0] model_pending;
  bit                model_pf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic exp_pix(input int h, input int v);
    int row;
    row = v / ROW_HEIGHT;
    if (h >= LINE_W || row >= ROWS) return 1'b0;
    if (row >= model_rows.size()) return 1'b1;
    return model_rows[row][h];
  endfunction

  function automatic logic [LINE_W-1:0] ones_except(input int k);
    logic [LINE_W-1:0] l;
    l = '1;
    if (k >= 0 && k < LINE_W) l[k] = 1'b0;
    return l;
  endfunction

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] l;
    for (int i = 0; i < LINE_W / 32; i++) l[i*32 +: 32] = $urandom();
    return l;
  endfunction

  always @(negedge clk) begin
    if (pix_valid) begin
      if (exp_q.size() == 0) check("pix_unexpected", 32'(pix_valid), 32'd0);
      else check("pix", 32'(pix), 32'(exp_q.pop_front()));
    end
  end

  task automatic read_pix(input int h, input int v);
    pix_req = 1'b1;
    hcount  = 10'(h);
    vcount  = 10'(v);
    exp_q.push_back(exp_pix(h, v));
    tick();
    pix_req = 1'b0;
    check("pix_valid", 32'(pix_valid), 32'd1);
  endtask

  task automatic push_line(input logic [LINE_W-1:0] l);
    bit acc;
    bit done;
    done = 1'b0;
    line_valid = 1'b1;
    line = l;
    for (int i = 0; i < 8 && !done; i++) begin
      acc = line_ready;
      tick();
      if (acc) done = 1'b1;
    end
    line_valid = 1'b0;
    if (done) begin
      model_pending = l;
      model_pf = 1'b1;
      check("ready_drop", 32'(line_ready), 32'd0);
    end else begin
      check("push_timeout", 32'd0, 32'd1);
    end
  endtask

  task automatic commit_model();
    model_rows.push_front(model_pending);
    if (model_rows.size() > ROWS) void'(model_rows.pop_back());
    model_pf = 1'b0;
  endtask

  task automatic frame(input bit rd = 1'b0, input int h = 0, input int v = 0);
    bit   did;
    bit   acc;
    logic hit_exp;
    did = model_pf;
    frame_start = 1'b1;
    if (rd) begin
      pix_req = 1'b1;
      hcount  = 10'(h);
      vcount  = 10'(v);
      exp_q.push_back(exp_pix(h, v));
    end
    tick();
    frame_start = 1'b0;
    pix_req = 1'b0;
    if (did) commit_model();
    hit_exp = did && model_rows.size() == ROWS && int'(player_col) < LINE_W
              && model_rows[ROWS-1][player_col] == 1'b0;
    check("hit_pulse", 32'(hit), 32'(hit_exp));
    check("fill", 32'(fill), 32'(model_rows.size()));
    check("ready_after_frame", 32'(line_ready), 32'd1);
    acc = line_valid && line_ready;
    tick();
    check("hit_clear", 32'(hit), 32'd0);
    if (acc) begin
      model_pending = line;
      model_pf = 1'b1;
      line_valid = 1'b0;
      check("ready_drop", 32'(line_ready), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LINE_W-1:0] l1;
    logic [LINE_W-1:0] l2;
    rst = 1'b1;
    line_valid = 1'b0;
    line = '0;
    frame_start = 1'b0;
    pix_req = 1'b0;
    hcount = '0;
    vcount = '0;
    player_col = 10'd1000;
    model_pf = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    check("rst_ready", 32'(line_ready), 32'd1);
    check("rst_pix", 32'(pix), 32'd0);
    check("rst_pix_valid", 32'(pix_valid), 32'd0);
    check("rst_hit", 32'(hit), 32'd0);
    check("rst_fill", 32'(fill), 32'd0);
    read_pix(100, 100);

    frame();
    push_line(ones_except(5));
    frame();
    read_pix(5, 0);
    read_pix(5, 15);
    read_pix(6, 0);
    read_pix(5, 16);

    l1 = rand_line();
    l2 = rand_line();
    push_line(l1);
    line_valid = 1'b1;
    line = l2;
    check("stall_ready", 32'(line_ready), 32'd0);
    tick();
    check("stall_hold", 32'(line_ready), 32'd0);
    frame();
    for (int i = 0; i < 4; i++) begin
      int c;
      c = $urandom_range(0, LINE_W - 1);
      read_pix(c, 0);
      read_pix(c, ROW_HEIGHT);
    end
    frame(1'b1, 10, 0);
    for (int i = 0; i < 4; i++) begin
      int c;
      c = $urandom_range(0, LINE_W - 1);
      read_pix(c, 0);
      read_pix(c, ROW_HEIGHT + 3);
      read_pix(c, 2 * ROW_HEIGHT);
    end

    for (int k = 1; k <= 31; k++) begin
      push_line(ones_except(k));
      frame();
    end
    read_pix(2, 29 * ROW_HEIGHT);
    read_pix(1, 29 * ROW_HEIGHT + 15);
    read_pix(31, 0);
    read_pix(639, 0);
    read_pix(640, 0);
    read_pix(0, 480);

    player_col = 10'd7;
    push_line(ones_except(7));
    frame();
    for (int i = 0; i < 30; i++) begin
      push_line('1);
      frame();
    end

    push_line(rand_line());
    #2;
    rst = 1'b1;
    #1;
    check("arst_ready", 32'(line_ready), 32'd1);
    check("arst_fill", 32'(fill), 32'd0);
    check("arst_hit", 32'(hit), 32'd0);
    check("arst_pix_valid", 32'(pix_valid), 32'd0);
    check("arst_pix", 32'(pix), 32'd0);
    model_rows.delete();
    model_pf = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    read_pix(0, 0);
    frame();

    repeat (2) tick();
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/line_field.md
# line_field

Frame-synchronous scrolling store for generated 640-bit obstacle lines, sitting between the line generator and the VGA pixel path. Accepts one line per handshake, holds it in a pending register, and commits it at the next frame start, where it becomes the top screen row while all older rows move down one. It serves single-pixel reads for the raster scan and flags a collision when the committed field's bottom row is blocked at the player column.

## Interface
- `LineWidth`, 640: bits per line; one bit per pixel column, 1 = open, 0 = blocked.
- `Rows`, 30: lines held and displayed.
- `RowHeight`, 16: scan lines per row; power of two.
- `clk_i`  in  1  single clock.
- `rst_i`  in  1  asynchronous, active-high reset.
- `line_valid_i`  in  1  producer offers `line_i`.
- `line_i`  in  LineWidth  line data; bit k is pixel column k.
- `line_ready_o`  out  1  pending register empty.
- `frame_start_i`  in  1  one-cycle pulse at the start of vertical blank.
- `pix_req_i`  in  1  pixel read strobe.
- `hcount_i`  in  10  pixel column.
- `vcount_i`  in  10  scan line.
- `pix_o`  out  1  pixel value.
- `pix_valid_o`  out  1  `pix_o` is valid.
- `player_col_i`  in  10  column checked for collision.
- `hit_o`  out  1  collision pulse.
- `fill_o`  out  $clog2(Rows+1)  number of committed rows, saturating.

## Operation
- Storage is `Rows` line slots in a circular buffer, plus `head` (the slot shown at screen row 0), a pending register, and a pending-full flag.
- Screen row r maps to slot (head + r) mod Rows. A row is filled when r < fill.
- `line_ready_o` = !pending_full, taken directly from the flag. A line is accepted when `line_valid_i` and `line_ready_o` are both high; it is latched into pending and pending_full is set.
- Commit happens on `frame_start_i` when pending_full is set:
  - head ← (head == 0) ? Rows−1 : head−1.
  - The slot at the new head ← pending.
  - pending_full is cleared.
  - fill ← min(fill+1, Rows).
  - The previous bottom row is discarded.
- `frame_start_i` with pending empty does nothing.
- There is no bypass. A line accepted in the same cycle as `frame_start_i` waits for the next frame start.
- Pixel read, registered: row = vcount_i >> log2(RowHeight).
  - If hcount_i ≥ LineWidth or row ≥ Rows, pix_o = 0.
  - Otherwise, if the row is unfilled, pix_o = 1.
  - Otherwise, pix_o = the stored bit at hcount_i.
- Collision check, one cycle after each commit:
  - Condition: fill == Rows and the bit at player_col_i of screen row Rows−1 == 0. This is evaluated on the post-commit state.
  - When the condition holds, hit_o pulses for one cycle.
  - If player_col_i ≥ LineWidth, there is never a hit.

## Timing
- Reset values: line_ready_o=1, pix_o=0, pix_valid_o=0, hit_o=0, fill_o=0, head=0, pending_full=0. Slot contents do not need to be reset.
- Reset mid-operation discards the pending line and all rows; the field reads as all-open (1).
- Read latency is 1: a request in cycle N gives pix_o/pix_valid_o in N+1. pix_valid_o is pix_req_i delayed by one cycle.
- A read in the same cycle as a commit returns pre-commit data.
- line_ready_o drops in the cycle after acceptance and rises in the cycle after commit.
- Only one line can be accepted per frame.
- hit_o rises exactly one cycle after the commit cycle.
- fill_o saturates at Rows. head wraps from 0 to Rows−1.

## Structure
- Shared package holds:
  - `LINE_W=640`, `SCREEN_H=480`.
  - The open/blocked bit encoding.
  - The row-index width function.
- Natural sub-module: `line_slot_mem`, the circular slot array with one write port and two read ports (pixel and collision).
- Control, head/fill tracking, and pending handshake live in `line_field`.

## Test plan
- Reset, then read (100,100) → pix_o=1 after 1 cycle, pix_valid_o=1, fill_o=0, line_ready_o=1.
- Push line with bit 5=0 (others 1), pulse frame_start → row 0 at (5,0..15)=0, (6,0)=1, (5,16)=1 (unfilled), fill_o=1.
- Push two lines L1, L2 with no frame_start between → second push stalls (line_ready_o=0). After frame_start, L1 is on row 0 and L2 is accepted. After the next frame_start, L2 is on row 0 and L1 is on row 1.
- Commit 31 lines, line k having bit k=0 → fill_o=30, head wrapped. Row 29 shows line 2's pattern: bit 2 is 0, bit 1 is open. Line 1 is discarded.
- With a full field and player_col_i=7, commit so that row 29 bit 7=0 → hit_o is high exactly one cycle after the commit. With bit 7=1 → no pulse.
- Assert rst_i mid-frame with pending_full set → all outputs return to reset values, and (0,0) reads 1.
